fetch_unit: RTL and testbench

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the program counter and drives a req/ack instruction-memory port. Presents `Instruction_F`/`NPC_F` together with `kill` and `disable_IR` so IF/ID either captures a valid instruction, inserts a NOP, or holds. A one-entry hold buffer absorbs a memory response that arrives while decode is stalled, and a drain state discards responses orphaned by a redirect.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_perf_cnt.sv | 22 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional perf counters build under FETCH_PERF_CNT_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/ack port between fetch and imem.
// Master drives req/addr; slave returns a one-cycle ack with data.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: consumed instructions and wait cycles.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_fetched,
  input  logic        inc_wait,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_wait    <= '0;
    end else begin
      if (inc_fetched) perf_fetched <= perf_fetched + 32'd1;
      if (inc_wait)    perf_wait    <= perf_wait + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack, hold buffer, drain.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_wait outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_if.master     imem,
  output logic [31:0] Instruction_F,
  output logic [31:0] NPC_F,
  output logic        kill,
  output logic        disable_IR
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
`endif
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  req_addr, req_addr_n;
  logic [31:0]  hold_instr, hold_n;
  logic         valid_c;
  logic         consume;
  logic         ack;

  assign ack     = imem.imem_ack;
  assign valid_c = ((state == S_REQ) && ack) || (state == S_HOLD);
  assign consume = valid_c && !stall && !redirect;

  assign imem.imem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign imem.imem_addr = req_addr;

  assign Instruction_F = (state == S_HOLD) ? hold_instr :
                         (valid_c ? imem.imem_rdata : FETCH_NOP);
  assign NPC_F         = pc + PC_INC;
  assign kill          = redirect || !valid_c;
  assign disable_IR    = stall && !redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_instr <= FETCH_NOP;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      hold_instr <= hold_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    hold_n     = hold_instr;
    if (redirect) begin
      pc_n = redirect_pc;
      // An unacked request must retire before the target is issued
      if (state == S_REQ && !ack) begin
        state_n = S_DRAIN;
      end else if (state != S_DRAIN) begin
        req_addr_n = redirect_pc;
        state_n    = S_REQ;
      end
    end else begin
      unique case (state)
        S_BOOT: state_n = S_REQ;
        S_REQ: begin
          if (consume) begin
            pc_n       = pc + PC_INC;
            req_addr_n = pc + PC_INC;
          end else if (ack && stall) begin
            hold_n  = imem.imem_rdata;
            state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            pc_n       = pc + PC_INC;
            req_addr_n = pc + PC_INC;
            state_n    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (ack) begin
            req_addr_n = pc;
            state_n    = S_REQ;
          end
        end
        default: state_n = S_BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk          (clk),
    .reset        (reset),
    .inc_fetched  (consume),
    .inc_wait     (imem.imem_req && !ack),
    .perf_fetched (perf_fetched),
    .perf_wait    (perf_wait)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps plus random memory latency.
// Perf counter checks compile in under FETCH_PERF_CNT_EN.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] Instruction_F;
  logic [31:0] NPC_F;
  logic        kill;
  logic        disable_IR;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_wait;
`endif

  fetch_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem          (imem.master),
    .Instruction_F (Instruction_F),
    .NPC_F         (NPC_F),
    .kill          (kill),
    .disable_IR    (disable_IR)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_wait     (perf_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: what fetch is waiting on, described as flags.
  bit          m_boot, m_pending, m_orphan, m_hold;
  logic [31:0] m_buf, m_pc, m_addr;
  logic [31:0] m_fetched, m_wait;
  int          mem_w, maxw;

  logic        o_req, o_kill, o_dis;
  logic [31:0] o_addr, o_npc, o_instr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot    = 1'b1;
    m_pending = 1'b0;
    m_orphan  = 1'b0;
    m_hold    = 1'b0;
    m_buf     = 32'h0;
    m_pc      = 32'h100;
    m_addr    = 32'h100;
    m_fetched = 32'h0;
    m_wait    = 32'h0;
    mem_w     = 0;
  endtask

  task automatic cycle(input bit st, input bit rd, input logic [31:0] rp);
    bit          ack, got, take;
    logic [31:0] rdata, e_instr;
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
    ack   = 1'b0;
    rdata = $urandom;
    if (m_pending) begin
      if (mem_w == 0) begin
        ack   = 1'b1;
        mem_w = (maxw > 0) ? int'($urandom_range(maxw, 0)) : 0;
      end else begin
        mem_w--;
      end
    end
    imem.imem_ack   = ack;
    imem.imem_rdata = rdata;
    #1;
    got     = (m_pending && !m_orphan && ack) || m_hold;
    take    = got && !st && !rd;
    e_instr = m_hold ? m_buf : (got ? rdata : 32'h0);
    chk("imem_req", {31'b0, imem.imem_req}, {31'b0, m_pending});
    if (m_pending) chk("imem_addr", imem.imem_addr, m_addr);
    chk("Instruction_F", Instruction_F, e_instr);
    chk("NPC_F", NPC_F, m_pc + 32'd4);
    chk("kill", {31'b0, kill}, {31'b0, rd || !got});
    chk("disable_IR", {31'b0, disable_IR}, {31'b0, st && !rd});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_wait", perf_wait, m_wait);
`endif
    o_req   = imem.imem_req;
    o_addr  = imem.imem_addr;
    o_npc   = NPC_F;
    o_instr = Instruction_F;
    o_kill  = kill;
    o_dis   = disable_IR;
    if (take) m_fetched = m_fetched + 32'd1;
    if (m_pending && !ack) m_wait = m_wait + 32'd1;
    if (rd) begin
      m_pc = rp;
      if (!m_orphan) begin
        if (m_pending && !ack) begin
          m_orphan = 1'b1;
        end else begin
          m_addr    = rp;
          m_pending = 1'b1;
          m_hold    = 1'b0;
          m_boot    = 1'b0;
        end
      end
    end else if (m_boot) begin
      m_boot    = 1'b0;
      m_pending = 1'b1;
    end else if (take) begin
      m_pc      = m_pc + 32'd4;
      m_addr    = m_pc;
      m_hold    = 1'b0;
      m_pending = 1'b1;
    end else if (m_pending && !m_orphan && ack && st) begin
      m_buf     = rdata;
      m_hold    = 1'b1;
      m_pending = 1'b0;
    end else if (m_orphan && ack) begin
      m_orphan = 1'b0;
      m_addr   = m_pc;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] word200;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    maxw = 0;
    model_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    #1;
    chk("rst imem_req", {31'b0, imem.imem_req}, 32'h0);
    chk("rst Instruction_F", Instruction_F, 32'h0);
    chk("rst NPC_F", NPC_F, 32'h104);
    chk("rst kill", {31'b0, kill}, 32'h1);
    chk("rst disable_IR hi", {31'b0, disable_IR}, 32'h1);
    stall = 1'b0;
    #1;
    chk("rst disable_IR lo", {31'b0, disable_IR}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst perf_fetched", perf_fetched, 32'h0);
    chk("rst perf_wait", perf_wait, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // zero-wait streaming from RESET_PC
    cycle(0, 0, 0);
    chk("boot no req", {31'b0, o_req}, 32'h0);
    cycle(0, 0, 0);
    chk("first addr", o_addr, 32'h100);
    chk("npc 104", o_npc, 32'h104);
    chk("first kill", {31'b0, o_kill}, 32'h0);
    cycle(0, 0, 0);
    chk("npc 108", o_npc, 32'h108);
    cycle(0, 0, 0);
    chk("npc 10c", o_npc, 32'h10C);

    // hold buffer across a 3-cycle stall
    cycle(0, 1, 32'h200);
    cycle(1, 0, 0);
    chk("hold ack addr", o_addr, 32'h200);
    word200 = o_instr;
    cycle(1, 0, 0);
    chk("hold req", {31'b0, o_req}, 32'h0);
    chk("hold instr 2", o_instr, word200);
    cycle(1, 0, 0);
    chk("hold instr 3", o_instr, word200);
    cycle(0, 0, 0);
    chk("release instr", o_instr, word200);
    chk("release kill", {31'b0, o_kill}, 32'h0);
    cycle(0, 0, 0);
    chk("after hold addr", o_addr, 32'h204);

    // redirect while 0x300 waits two cycles
    cycle(0, 1, 32'h300);
    mem_w = 2;
    cycle(0, 1, 32'h400);
    chk("drain addr a", o_addr, 32'h300);
    cycle(0, 0, 0);
    chk("drain addr b", o_addr, 32'h300);
    cycle(0, 0, 0);
    chk("drain addr c", o_addr, 32'h300);
    chk("drain kill", {31'b0, o_kill}, 32'h1);
    cycle(1, 0, 0);
    chk("target addr", o_addr, 32'h400);

    // redirect beats stall in S_HOLD
    cycle(1, 1, 32'h500);
    chk("rs disable_IR", {31'b0, o_dis}, 32'h0);
    chk("rs kill", {31'b0, o_kill}, 32'h1);
    cycle(0, 1, 32'hFFFF_FFFC);
    chk("rs next addr", o_addr, 32'h500);

    // PC wrap
    cycle(0, 0, 0);
    chk("wrap npc", o_npc, 32'h0);
    cycle(0, 0, 0);
    chk("wrap addr", o_addr, 32'h0);

    // random latency, stalls and redirects
    maxw = 2;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(9, 0) < 3), ($urandom_range(9, 0) == 0),
            {$urandom_range(32'h3FFF, 0), 2'b00});
    end

    // reset while draining
    maxw = 0;
    reset = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 0, 0);
    mem_w = 3;
    cycle(0, 1, 32'h800);
    cycle(0, 0, 0);
    chk("pre-reset drain req", {31'b0, o_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("drain rst req", {31'b0, imem.imem_req}, 32'h0);
    chk("drain rst kill", {31'b0, kill}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    chk("drain rst perf_fetched", perf_fetched, 32'h0);
    chk("drain rst perf_wait", perf_wait, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 0, 0);
    chk("rst boot no req", {31'b0, o_req}, 32'h0);
    cycle(0, 0, 0);
    chk("rst first addr", o_addr, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
